// File: rtl/serdes_pulse_decoder_pkg.sv
// Shared definitions for the SERDES pulse decoder: CSR opcodes, capture modes,
// status bit positions and the capture state enum.
package serdes_pulse_decoder_pkg;

  localparam logic [1:0] OP_SET_MODE = 2'b00;
  localparam logic [1:0] OP_ACK      = 2'b01;

  typedef enum logic [1:0] {
    M_DISABLED   = 2'd0,
    M_SINGLE     = 2'd1,
    M_CONTINUOUS = 2'd2,
    M_RESERVED   = 2'd3
  } mode_e;

  localparam int unsigned ST_DELAY_OVF = 0;
  localparam int unsigned ST_WIDTH_OVF = 1;
  localparam int unsigned ST_RETRIGGER = 2;
  localparam int unsigned ST_OVERRUN   = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_SEEK,
    S_PULSE,
    S_DONE
  } state_e;

  // Reserved encoding behaves exactly like DISABLED.
  function automatic logic mode_active(input mode_e m);
    return (m == M_SINGLE) || (m == M_CONTINUOUS);
  endfunction

endpackage

// File: rtl/serdes_pulse_decoder_word_classify.sv
// Combinational all-zeros / all-ones flags for a word of arbitrary width.
module serdes_word_classify #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] word,
  output logic             isZero,
  output logic             isOnes
);

  assign isZero = (word == '0);
  assign isOnes = (word == '1);

endmodule

// File: rtl/serdes_pulse_decoder.sv
// Recovers coarse delay/width of an EVR output pulse from the deserialized word stream.
// Optional PULSE_DECODER_TIMESTAMP_EN adds a trigger timestamp output.
module serdes_pulse_decoder
  import serdes_pulse_decoder_pkg::*;
#(
  parameter int unsigned SERDES_WIDTH       = 4,
  parameter int unsigned COARSE_DELAY_WIDTH = 22,
  parameter int unsigned COARSE_WIDTH_WIDTH = 22
) (
  input  logic                                       evrClk,
  input  logic                                       evrRst_n,
  input  logic                                       csrStrobe,
  input  logic [31:0]                                csrData,
  input  logic                                       triggerStrobe,
  input  logic [SERDES_WIDTH-1:0]                    serdesWord,
  output logic                                       resultValid,
  output logic [COARSE_DELAY_WIDTH+SERDES_WIDTH-1:0] resultDelay,
  output logic [COARSE_WIDTH_WIDTH+SERDES_WIDTH-1:0] resultWidth,
  output logic [3:0]                                 status,
  output logic                                       busy
`ifdef PULSE_DECODER_TIMESTAMP_EN
  ,
  output logic [31:0]                                resultTimestamp
`endif
);

  localparam int unsigned SW = SERDES_WIDTH;
  localparam int unsigned DW = COARSE_DELAY_WIDTH;
  localparam int unsigned WW = COARSE_WIDTH_WIDTH;

  localparam logic [DW-1:0] DLY_ONE = DW'(1);
  localparam logic [WW-1:0] WID_ONE = WW'(1);

  // Input register stage
  logic          r_stb;
  logic [1:0]    r_op;
  mode_e         r_mode;
  logic          r_trig;
  logic [SW-1:0] r_word;

  always_ff @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      r_stb  <= 1'b0;
      r_op   <= '0;
      r_mode <= M_DISABLED;
      r_trig <= 1'b0;
      r_word <= '0;
    end else begin
      r_stb  <= csrStrobe;
      r_op   <= csrData[31:30];
      r_mode <= mode_e'(csrData[1:0]);
      r_trig <= triggerStrobe;
      r_word <= serdesWord;
    end
  end

  state_e        state;
  mode_e         mode;
  logic [DW-1:0] delay_cnt;
  logic [WW-1:0] width_cnt;
  logic [SW-1:0] last_word;

  logic word_zero, word_ones;
  logic delay_zero, delay_ones;
  logic width_zero, width_ones;

  serdes_word_classify #(.WIDTH(SW)) u_word_cls (
    .word   (r_word),
    .isZero (word_zero),
    .isOnes (word_ones)
  );

  serdes_word_classify #(.WIDTH(DW)) u_dly_cls (
    .word   (delay_cnt),
    .isZero (delay_zero),
    .isOnes (delay_ones)
  );

  serdes_word_classify #(.WIDTH(WW)) u_wid_cls (
    .word   (width_cnt),
    .isZero (width_zero),
    .isOnes (width_ones)
  );

  logic unused_bits;
  assign unused_bits = word_ones ^ delay_zero ^ (^csrData[29:2]);

  logic          set_mode;
  logic          ack;
  logic          trig;
  logic          disable_req;
  logic [WW-1:0] width_final;

  assign set_mode    = r_stb && (r_op == OP_SET_MODE);
  assign ack         = r_stb && (r_op == OP_ACK);
  // ACK wins over a simultaneous trigger: the trigger is dropped entirely.
  assign trig        = r_trig && !ack;
  assign disable_req = set_mode && !mode_active(r_mode);
  assign width_final = width_zero ? '0 : (width_cnt - WID_ONE);

  assign busy = (state == S_ARMED) || (state == S_SEEK) || (state == S_PULSE);

  always_ff @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      state       <= S_IDLE;
      mode        <= M_DISABLED;
      delay_cnt   <= '0;
      width_cnt   <= '0;
      last_word   <= '0;
      resultValid <= 1'b0;
      resultDelay <= '0;
      resultWidth <= '0;
      status      <= '0;
    end else begin
      if (set_mode) mode <= r_mode;
      if (ack) begin
        resultValid <= 1'b0;
        status      <= '0;
      end

      if (disable_req) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (mode_active(mode)) state <= S_ARMED;
          end

          S_ARMED: begin
            if (trig) begin
              resultValid <= 1'b0;
              delay_cnt   <= '0;
              state       <= S_SEEK;
            end
          end

          S_SEEK: begin
            // The word sharing a cycle with a (re)trigger is not part of the capture.
            if (trig) begin
              delay_cnt                <= '0;
              status[ST_RETRIGGER]     <= 1'b1;
            end else if (!word_zero) begin
              resultDelay <= {delay_cnt, r_word};
              last_word   <= r_word;
              width_cnt   <= '0;
              state       <= S_PULSE;
            end else if (delay_ones) begin
              // Overflow still publishes a (sentinel) result so software sees completion.
              status[ST_DELAY_OVF] <= 1'b1;
              resultDelay          <= {{DW{1'b1}}, {SW{1'b0}}};
              resultWidth          <= '0;
              resultValid          <= 1'b1;
              state                <= S_DONE;
            end else begin
              delay_cnt <= delay_cnt + DLY_ONE;
            end
          end

          S_PULSE: begin
            if (trig) status[ST_OVERRUN] <= 1'b1;
            if (word_zero) begin
              resultWidth <= {width_final, last_word};
              resultValid <= 1'b1;
              state       <= S_DONE;
            end else if (width_ones) begin
              status[ST_WIDTH_OVF] <= 1'b1;
              resultWidth          <= {{WW{1'b1}}, r_word};
              resultValid          <= 1'b1;
              state                <= S_DONE;
            end else begin
              last_word <= r_word;
              width_cnt <= width_cnt + WID_ONE;
            end
          end

          S_DONE: begin
            if (trig) status[ST_OVERRUN] <= 1'b1;
            if ((mode == M_CONTINUOUS) || ack) state <= S_ARMED;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef PULSE_DECODER_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic        trig_accept;

  assign trig_accept = trig && !disable_req && ((state == S_ARMED) || (state == S_SEEK));

  always_ff @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      ts_cnt          <= '0;
      resultTimestamp <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (trig_accept) resultTimestamp <= ts_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_serdes_pulse_decoder.sv
// Self-checking bench for serdes_pulse_decoder with a stream-level reference model.
module tb_serdes_pulse_decoder;

  localparam int unsigned SW = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned WW = 4;
  localparam int DMAX = 16;
  localparam int WMAX = 16;

  localparam logic [1:0] OP_SET = 2'b00;
  localparam logic [1:0] OP_ACK = 2'b01;
  localparam logic [1:0] MD_SINGLE = 2'd1;
  localparam logic [1:0] MD_CONT   = 2'd2;
  localparam logic [1:0] MD_RSV    = 2'd3;

  logic        evrClk = 1'b0;
  logic        evrRst_n;
  logic        csrStrobe;
  logic [31:0] csrData;
  logic        triggerStrobe;
  logic [3:0]  serdesWord;
  logic        resultValid;
  logic [7:0]  resultDelay;
  logic [7:0]  resultWidth;
  logic [3:0]  status;
  logic        busy;
`ifdef PULSE_DECODER_TIMESTAMP_EN
  logic [31:0] resultTimestamp;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] stim[$];
  logic [7:0] exp_d, exp_w;
  logic [3:0] exp_s;

  serdes_pulse_decoder #(
    .SERDES_WIDTH       (SW),
    .COARSE_DELAY_WIDTH (DW),
    .COARSE_WIDTH_WIDTH (WW)
  ) dut (
    .evrClk          (evrClk),
    .evrRst_n        (evrRst_n),
    .csrStrobe       (csrStrobe),
    .csrData         (csrData),
    .triggerStrobe   (triggerStrobe),
    .serdesWord      (serdesWord),
    .resultValid     (resultValid),
    .resultDelay     (resultDelay),
    .resultWidth     (resultWidth),
    .status          (status),
`ifdef PULSE_DECODER_TIMESTAMP_EN
    .resultTimestamp (resultTimestamp),
`endif
    .busy            (busy)
  );

  always #5 evrClk = ~evrClk;

  task automatic tick();
    @(posedge evrClk);
    #1;
  endtask

  task automatic csr_write(input logic [1:0] op, input logic [1:0] m);
    csrData   = {op, 28'd0, m};
    csrStrobe = 1'b1;
    tick();
    csrStrobe = 1'b0;
    csrData   = '0;
    repeat (3) tick();
  endtask

  // Trigger, then present stim[] one word per cycle, then wait (bounded) for a result.
  task automatic run_capture();
    triggerStrobe = 1'b1;
    serdesWord    = 4'h0;
    tick();
    triggerStrobe = 1'b0;
    foreach (stim[k]) begin
      serdesWord = stim[k];
      tick();
    end
    serdesWord = 4'h0;
    for (int i = 0; i < 20; i++) begin
      if (resultValid === 1'b1) break;
      tick();
    end
  endtask

  // Reference: locate the pulse in the post-trigger stream and derive the payloads.
  function automatic void model(output logic [7:0] d, output logic [7:0] w, output logic [3:0] st);
    int first;
    int len;
    first = -1;
    len   = 0;
    d     = '0;
    w     = '0;
    st    = '0;
    for (int k = 0; k < stim.size() && k < DMAX; k++) begin
      if (stim[k] != 4'h0) begin
        first = k;
        break;
      end
    end
    if (first < 0) begin
      st[0] = 1'b1;
      d     = 8'hF0;
      return;
    end
    while ((first + len) < stim.size() && stim[first + len] != 4'h0) len++;
    d = {4'(first), stim[first]};
    if (len > WMAX) begin
      st[1] = 1'b1;
      w     = {4'hF, stim[first + WMAX]};
    end else begin
      w = {4'((len >= 2) ? len - 2 : 0), stim[first + len - 1]};
    end
  endfunction

  task automatic test_reset();
    n_checks++; if (resultValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", resultValid); end
    n_checks++; if (resultDelay !== 8'h00) begin n_fail++; $display("FAIL reset_delay: got %h expected 00", resultDelay); end
    n_checks++; if (resultWidth !== 8'h00) begin n_fail++; $display("FAIL reset_width: got %h expected 00", resultWidth); end
    n_checks++; if (status !== 4'h0) begin n_fail++; $display("FAIL reset_status: got %b expected 0000", status); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef PULSE_DECODER_TIMESTAMP_EN
    n_checks++; if (resultTimestamp !== 32'd0) begin n_fail++; $display("FAIL reset_ts: got %h expected 0", resultTimestamp); end
`endif
  endtask

  task automatic test_directed();
    csr_write(OP_SET, MD_CONT);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL armed_busy: got %b expected 1", busy); end

    stim.delete();
    repeat (12) stim.push_back(4'hF);
    repeat (3) stim.push_back(4'h0);
    run_capture();
    n_checks++; if (resultValid !== 1'b1) begin n_fail++; $display("FAIL d1_valid: got %b expected 1", resultValid); end
    n_checks++; if (resultDelay !== 8'h0F) begin n_fail++; $display("FAIL d1_delay: got %h expected 0f", resultDelay); end
    n_checks++; if (resultWidth !== 8'hAF) begin n_fail++; $display("FAIL d1_width: got %h expected af", resultWidth); end

    csr_write(OP_ACK, 2'd0);
    n_checks++; if (resultValid !== 1'b0) begin n_fail++; $display("FAIL ack_clears_valid: got %b expected 0", resultValid); end
    stim.delete();
    repeat (5) stim.push_back(4'h0);
    stim.push_back(4'h8); stim.push_back(4'hF); stim.push_back(4'h1);
    repeat (3) stim.push_back(4'h0);
    run_capture();
    n_checks++; if (resultDelay !== 8'h58) begin n_fail++; $display("FAIL d2_delay: got %h expected 58", resultDelay); end
    n_checks++; if (resultWidth !== 8'h11) begin n_fail++; $display("FAIL d2_width: got %h expected 11", resultWidth); end
    n_checks++; if (status !== 4'h0) begin n_fail++; $display("FAIL d2_status: got %b expected 0000", status); end

    csr_write(OP_ACK, 2'd0);
    stim.delete();
    repeat (20) stim.push_back(4'h0);
    run_capture();
    n_checks++; if (resultValid !== 1'b1) begin n_fail++; $display("FAIL dovf_valid: got %b expected 1", resultValid); end
    n_checks++; if (resultDelay !== 8'hF0) begin n_fail++; $display("FAIL dovf_delay: got %h expected f0", resultDelay); end
    n_checks++; if (resultWidth !== 8'h00) begin n_fail++; $display("FAIL dovf_width: got %h expected 00", resultWidth); end
    n_checks++; if (status !== 4'b0001) begin n_fail++; $display("FAIL dovf_status: got %b expected 0001", status); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int d;
      int l;
      d = int'($urandom_range(0, 17));
      l = int'($urandom_range(1, 18));
      stim.delete();
      repeat (d) stim.push_back(4'h0);
      repeat (l) stim.push_back(4'($urandom_range(1, 15)));
      repeat (3) stim.push_back(4'h0);
      model(exp_d, exp_w, exp_s);
      csr_write(OP_ACK, 2'd0);
      run_capture();
      n_checks++; if (resultValid !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_valid: got %b expected 1", n, resultValid); end
      n_checks++; if (resultDelay !== exp_d) begin n_fail++; $display("FAIL rnd%0d_delay: got %h expected %h (d=%0d l=%0d)", n, resultDelay, exp_d, d, l); end
      n_checks++; if (resultWidth !== exp_w) begin n_fail++; $display("FAIL rnd%0d_width: got %h expected %h (d=%0d l=%0d)", n, resultWidth, exp_w, d, l); end
      n_checks++; if (status !== exp_s) begin n_fail++; $display("FAIL rnd%0d_status: got %b expected %b", n, status, exp_s); end
    end
  endtask

  task automatic test_retrigger();
    csr_write(OP_ACK, 2'd0);
    triggerStrobe = 1'b1;
    serdesWord    = 4'h0;
    tick();
    triggerStrobe = 1'b0;
    repeat (3) tick();
    triggerStrobe = 1'b1;
    tick();
    triggerStrobe = 1'b0;
    stim.delete();
    stim.push_back(4'h0); stim.push_back(4'h0); stim.push_back(4'h3);
    repeat (3) stim.push_back(4'h0);
    foreach (stim[k]) begin
      serdesWord = stim[k];
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      if (resultValid === 1'b1) break;
      tick();
    end
    n_checks++; if (resultValid !== 1'b1) begin n_fail++; $display("FAIL retrig_valid: got %b expected 1", resultValid); end
    n_checks++; if (resultDelay !== 8'h23) begin n_fail++; $display("FAIL retrig_delay: got %h expected 23", resultDelay); end
    n_checks++; if (resultWidth !== 8'h03) begin n_fail++; $display("FAIL retrig_width: got %h expected 03", resultWidth); end
    n_checks++; if (status !== 4'b0100) begin n_fail++; $display("FAIL retrig_status: got %b expected 0100", status); end
  endtask

  task automatic test_single_overrun();
    csr_write(OP_SET, MD_SINGLE);
    csr_write(OP_ACK, 2'd0);
    stim.delete();
    stim.push_back(4'h6);
    repeat (3) stim.push_back(4'h0);
    run_capture();
    n_checks++; if (resultDelay !== 8'h06) begin n_fail++; $display("FAIL single_delay: got %h expected 06", resultDelay); end
    n_checks++; if (resultWidth !== 8'h06) begin n_fail++; $display("FAIL single_width: got %h expected 06", resultWidth); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_done_busy: got %b expected 0", busy); end
    triggerStrobe = 1'b1;
    tick();
    triggerStrobe = 1'b0;
    repeat (5) tick();
    n_checks++; if (status !== 4'b1000) begin n_fail++; $display("FAIL overrun_status: got %b expected 1000", status); end
    n_checks++; if (resultValid !== 1'b1) begin n_fail++; $display("FAIL overrun_valid: got %b expected 1", resultValid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_hold_busy: got %b expected 0", busy); end
    csr_write(OP_ACK, 2'd0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ack_rearm_busy: got %b expected 1", busy); end
    n_checks++; if (status !== 4'b0000) begin n_fail++; $display("FAIL ack_status: got %b expected 0000", status); end
  endtask

  task automatic test_ack_trigger_same_cycle();
    stim.delete();
    stim.push_back(4'h9);
    repeat (3) stim.push_back(4'h0);
    run_capture();
    n_checks++; if (resultDelay !== 8'h09) begin n_fail++; $display("FAIL at_delay: got %h expected 09", resultDelay); end
    csrData       = {OP_ACK, 30'd0};
    csrStrobe     = 1'b1;
    triggerStrobe = 1'b1;
    tick();
    csrStrobe     = 1'b0;
    triggerStrobe = 1'b0;
    csrData       = '0;
    serdesWord    = 4'h2;
    tick();
    serdesWord    = 4'h0;
    repeat (6) tick();
    n_checks++; if (resultValid !== 1'b0) begin n_fail++; $display("FAIL at_valid: got %b expected 0", resultValid); end
    n_checks++; if (status !== 4'b0000) begin n_fail++; $display("FAIL at_status: got %b expected 0000", status); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL at_busy: got %b expected 1", busy); end
  endtask

  task automatic test_reserved_mode();
    csr_write(OP_SET, MD_RSV);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rsv_busy: got %b expected 0", busy); end
    stim.delete();
    stim.push_back(4'h1);
    repeat (3) stim.push_back(4'h0);
    run_capture();
    n_checks++; if (resultValid !== 1'b0) begin n_fail++; $display("FAIL rsv_valid: got %b expected 0", resultValid); end
  endtask

`ifdef PULSE_DECODER_TIMESTAMP_EN
  task automatic test_timestamp();
    logic [31:0] ts1;
    logic [31:0] ts2;
    csr_write(OP_SET, MD_CONT);
    triggerStrobe = 1'b1;
    serdesWord    = 4'h0;
    tick();
    triggerStrobe = 1'b0;
    for (int i = 0; i < 127; i++) begin
      serdesWord = (i == 0) ? 4'h1 : 4'h0;
      tick();
    end
    ts1 = resultTimestamp;
    n_checks++; if (resultValid !== 1'b1) begin n_fail++; $display("FAIL ts1_valid: got %b expected 1", resultValid); end
    triggerStrobe = 1'b1;
    serdesWord    = 4'h0;
    tick();
    triggerStrobe = 1'b0;
    for (int i = 0; i < 127; i++) begin
      serdesWord = (i == 0) ? 4'h1 : 4'h0;
      tick();
    end
    ts2 = resultTimestamp;
    n_checks++; if (resultValid !== 1'b1) begin n_fail++; $display("FAIL ts2_valid: got %b expected 1", resultValid); end
    n_checks++; if ((ts2 - ts1) !== 32'd128) begin n_fail++; $display("FAIL ts_delta: got %0d expected 128", ts2 - ts1); end
  endtask
`endif

  task automatic test_reset_mid_pulse();
    csr_write(OP_SET, MD_CONT);
    triggerStrobe = 1'b1;
    serdesWord    = 4'h0;
    tick();
    triggerStrobe = 1'b0;
    serdesWord    = 4'hF;
    repeat (3) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", busy); end
    n_checks++; if (resultDelay !== 8'h0F) begin n_fail++; $display("FAIL mid_delay: got %h expected 0f", resultDelay); end
    #1;
    evrRst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (resultDelay !== 8'h00) begin n_fail++; $display("FAIL rst_delay: got %h expected 00", resultDelay); end
    n_checks++; if (resultWidth !== 8'h00) begin n_fail++; $display("FAIL rst_width: got %h expected 00", resultWidth); end
    n_checks++; if (resultValid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", resultValid); end
    #3;
    evrRst_n = 1'b1;
    tick();
    serdesWord = 4'h0;
    repeat (10) tick();
    n_checks++; if (resultValid !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid: got %b expected 0", resultValid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy: got %b expected 0", busy); end
  endtask

  initial begin
    evrRst_n      = 1'b0;
    csrStrobe     = 1'b0;
    csrData       = '0;
    triggerStrobe = 1'b0;
    serdesWord    = 4'h0;
    #1;
    test_reset();
    repeat (3) tick();
    evrRst_n = 1'b1;
    repeat (2) tick();
    test_reset();
    test_directed();
    test_random();
    test_retrigger();
    test_single_overrun();
    test_ack_trigger_same_cycle();
    test_reserved_mode();
`ifdef PULSE_DECODER_TIMESTAMP_EN
    test_timestamp();
`endif
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serdes_pulse_decoder.md
# serdes_pulse_decoder

Receive-side counterpart of the EVR output driver. It watches a deserialized SERDES word stream in the EVR clock domain and, after each event trigger, recovers the pulse parameters that produced it: coarse delay with first word, and coarse width with last word. Results are packed exactly as the driver's SET_DELAY and SET_WIDTH CSR payloads, so loopback self-test and external-input checking can compare them directly against programmed values.

## Interface
Parameters:
- SERDES_WIDTH, 4: bits per word; LSB is the earliest bit.
- COARSE_DELAY_WIDTH, 22: width of the coarse-delay counter.
- COARSE_WIDTH_WIDTH, 22: width of the coarse-width counter.

Ports:
- evrClk  in  1  sole clock.
- evrRst_n  in  1  asynchronous, active-low reset.
- csrStrobe  in  1  control-word strobe, synchronous to evrClk.
- csrData  in  32  control word. [31:30]=opcode: 00 SET_MODE with [1:0]=mode; 01 ACK.
- triggerStrobe  in  1  event trigger, one cycle.
- serdesWord  in  SERDES_WIDTH  sampled word.
- resultValid  out  1  result held; cleared by ACK or by a new capture start.
- resultDelay  out  COARSE_DELAY_WIDTH+SERDES_WIDTH  {coarseDelay, firstWord}.
- resultWidth  out  COARSE_WIDTH_WIDTH+SERDES_WIDTH  {coarseWidth, lastWord}.
- status  out  4  {overrun, retrigger, widthOvf, delayOvf}; sticky, cleared by ACK.
- busy  out  1  state is not IDLE or DONE.

## Operation
Modes, in the shared package:
- M_DISABLED = 0
- M_SINGLE = 1: one capture, then DONE until ACK.
- M_CONTINUOUS = 2: DONE returns to ARMED.
- 3 is reserved and behaves as M_DISABLED.

States: IDLE, ARMED, SEEK, PULSE, DONE.
- IDLE → ARMED when mode ≠ DISABLED.
- ARMED → SEEK on triggerStrobe. Clears resultValid; delayCnt = 0.
- SEEK: the word in the cycle after the trigger has coarse delay 0.
  - First nonzero word: latch coarseDelay = delayCnt and firstWord, set lastWord = word, widthCnt = 0, go to PULSE.
  - Otherwise delayCnt++.
  - delayCnt at all-ones with no nonzero word: set delayOvf, resultDelay = {all-ones, 0}, resultWidth = 0, go to DONE.
- PULSE, per word:
  - Zero word: finish. coarseWidth = widthCnt − 1, or 0 if widthCnt = 0. Result last = lastWord. Go to DONE, set resultValid.
  - Nonzero word: lastWord = word, widthCnt++.
  - widthCnt saturating: set widthOvf, finish with width all-ones.
- DONE: M_SINGLE holds until ACK, then → ARMED. M_CONTINUOUS → ARMED in the next cycle; resultValid stays set until the next trigger.
- Trigger in SEEK: restart delayCnt = 0 and set retrigger.
- Trigger in PULSE or DONE: ignored, set overrun.
- SET_MODE DISABLED in any state → IDLE. resultValid and status are kept.
- ACK and a trigger in the same cycle: ACK is processed first, the trigger is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, mode M_DISABLED.
- SET_MODE takes effect on the cycle after csrStrobe.
- Inputs are registered once. resultValid rises 2 evrClk after the first zero word is presented.
- Worst-case bound per capture: (2^COARSE_DELAY_WIDTH + 2^COARSE_WIDTH_WIDTH + 3) cycles.
- Minimum re-arm gap in M_CONTINUOUS: 1 cycle after DONE.

## Configuration
- PULSE_DECODER_TIMESTAMP_EN defined:
  - Adds output resultTimestamp [31:0], driven by a free-running 32-bit cycle counter that wraps and resets to 0.
  - The counter value is latched on the accepted trigger and is valid together with resultValid.
- Undefined: no counter and no port.

## Structure
- Shared package holds the opcode constants (OP_SET_MODE, OP_ACK), mode encodings, the status bit indices and the state enum.
- One sub-module, serdes_word_classify: combinational flags isZero and isOnes for a word.

## Test plan
- Mode CONTINUOUS; trigger; 0 zero words, then 12 words of 4'hF, then 0 → resultDelay = 0x0F, resultWidth = 0xAF (width 10, last F).
- Trigger; 5 zero words, then 4'h8, 4'hF, 4'h1, 0 → resultDelay = {5, 4'h8}, resultWidth = {1, 4'h1}.
- Single nonzero word 4'h6 → delay 0, firstWord 6, resultWidth = {0, 4'h6}. Mode SINGLE holds DONE until ACK; a trigger while in DONE sets status[3] (overrun).
- Second trigger during SEEK after 3 words → retrigger bit set; delay measured from the second trigger.
- Shrink COARSE_DELAY_WIDTH to 4 and drive no pulse → delayOvf after 16 words, resultDelay = {4'hF, 4'h0}.
- Reset asserted mid-PULSE → all outputs 0 immediately; no result until re-armed. With PULSE_DECODER_TIMESTAMP_EN, two triggers 128 cycles apart give timestamps differing by 128.
